// File: rtl/alu_logic_sequencer_if.sv
// Bundle between the logic-unit sequencer and its environment.
// ALU_SEQ_FLAGS_EN adds the zero/negative result flags.
interface alu_logic_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] bus_in;
  logic [WIDTH-1:0] logic_result;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic             and_sel;
  logic             or_sel;
  logic             not_sel;
  logic [WIDTH-1:0] z_out;
  logic             busy;
  logic             done;
  logic             err;
`ifdef ALU_SEQ_FLAGS_EN
  logic             zero_flag;
  logic             neg_flag;
`endif

  modport master (
    output start, op, bus_in, logic_result,
    input  alu_a, alu_b, and_sel, or_sel, not_sel,
    input  z_out, busy, done, err
`ifdef ALU_SEQ_FLAGS_EN
    , input zero_flag, neg_flag
`endif
  );

  modport slave (
    input  start, op, bus_in, logic_result,
    output alu_a, alu_b, and_sel, or_sel, not_sel,
    output z_out, busy, done, err
`ifdef ALU_SEQ_FLAGS_EN
    , output zero_flag, neg_flag
`endif
  );
endinterface

// File: rtl/alu_logic_sequencer.sv
// Loads A then B from the shared bus, drives the AND/OR/NOT unit, latches Z.
// ALU_SEQ_FLAGS_EN adds registered zero_flag/neg_flag alongside Z.
module alu_logic_sequencer #(
  parameter int WIDTH = 32
) (
  input logic                 clock,
  input logic                 clear,
  alu_logic_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD_B,
    S_EXEC,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_y;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_z;
  logic [1:0]       r_op;
  logic             r_done;
  logic             r_err;
  logic             w_and_sel;
  logic             w_or_sel;
  logic             w_not_sel;
  logic             w_capture;
  logic             w_legal;
  logic [WIDTH-1:0] w_result;
`ifdef ALU_SEQ_FLAGS_EN
  logic             r_zero;
  logic             r_neg;
`endif

  always_ff @(posedge clock or posedge clear) begin
    if (clear) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_and_sel = 1'b0;
    w_or_sel  = 1'b0;
    w_not_sel = 1'b0;
    unique case (r_state)
      S_IDLE:   if (bus.start) w_next = S_LOAD_B;
      S_LOAD_B: w_next = S_EXEC;
      S_EXEC: begin
        w_next = S_DONE;
        unique case (r_op)
          2'b00:   w_and_sel = 1'b1;
          2'b01:   w_or_sel  = 1'b1;
          2'b10:   w_not_sel = 1'b1;
          default: ;
        endcase
      end
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  assign w_capture = (r_state == S_EXEC);
  assign w_legal   = (r_op != 2'b11);
  assign w_result  = w_legal ? bus.logic_result : '0;

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_y    <= '0;
      r_b    <= '0;
      r_z    <= '0;
      r_op   <= 2'b00;
      r_done <= 1'b0;
      r_err  <= 1'b0;
`ifdef ALU_SEQ_FLAGS_EN
      r_zero <= 1'b0;
      r_neg  <= 1'b0;
`endif
    end else begin
      r_done <= w_capture;
      r_err  <= w_capture && !w_legal;
      if (r_state == S_IDLE && bus.start) begin
        r_y  <= bus.bus_in;
        r_op <= bus.op;
      end
      // B is loaded even for NOT so every op has the same latency
      if (r_state == S_LOAD_B) r_b <= bus.bus_in;
      if (w_capture) begin
        r_z <= w_result;
`ifdef ALU_SEQ_FLAGS_EN
        r_zero <= (w_result == '0);
        r_neg  <= w_result[WIDTH-1];
`endif
      end
    end
  end

  assign bus.alu_a   = r_y;
  assign bus.alu_b   = r_b;
  assign bus.and_sel = w_and_sel;
  assign bus.or_sel  = w_or_sel;
  assign bus.not_sel = w_not_sel;
  assign bus.z_out   = r_z;
  assign bus.busy    = (r_state != S_IDLE);
  assign bus.done    = r_done;
  assign bus.err     = r_err;
`ifdef ALU_SEQ_FLAGS_EN
  assign bus.zero_flag = r_zero;
  assign bus.neg_flag  = r_neg;
`endif

endmodule

// File: tb/tb_alu_logic_sequencer.sv
// Scoreboard bench for alu_logic_sequencer with a behavioural logic unit.
// Flag checks are compiled in when ALU_SEQ_FLAGS_EN is defined.
module tb_alu_logic_sequencer;
  localparam int W = 32;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] z;
    logic         err;
    logic         zf;
    logic         nf;
    int           t;
  } exp_t;

  logic clock = 1'b0;
  logic clear = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t sb[$];

  alu_logic_sequencer_if #(.WIDTH(W)) bus_if ();

  alu_logic_sequencer #(.WIDTH(W)) dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus_if)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  assign bus_if.logic_result =
    bus_if.and_sel ? (bus_if.alu_a & bus_if.alu_b) :
    bus_if.or_sel  ? (bus_if.alu_a | bus_if.alu_b) :
    bus_if.not_sel ? ~bus_if.alu_a : 32'hBAD0_BAD0;

  task automatic chk(input string nm, input logic [W-1:0] act,
                     input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, req);
    end
  endtask

  // Monitor: selects each cycle, scoreboard pop on every done
  initial begin : monitor
    int n_and, n_or, n_not;
    logic prev_done;
    exp_t e;
    n_and = 0; n_or = 0; n_not = 0;
    prev_done = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      if (clear) begin
        n_and = 0; n_or = 0; n_not = 0;
        prev_done = 1'b0;
        continue;
      end
      chk("sel_onehot_idle",
          {31'd0, ($countones({bus_if.and_sel, bus_if.or_sel,
                               bus_if.not_sel}) > 1) ||
                  (!bus_if.busy && (bus_if.and_sel || bus_if.or_sel ||
                                    bus_if.not_sel))}, '0);
      n_and += int'(bus_if.and_sel);
      n_or  += int'(bus_if.or_sel);
      n_not += int'(bus_if.not_sel);
      if (bus_if.done) begin
        chk("done_adjacent", {31'd0, prev_done}, '0);
        if (sb.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("z_out", bus_if.z_out, e.z);
          chk("err", {31'd0, bus_if.err}, {31'd0, e.err});
          chk("latency", cyc - e.t, 32'd3);
          chk("alu_a", bus_if.alu_a, e.a);
          chk("alu_b", bus_if.alu_b, e.b);
          chk("and_cycles", n_and, {31'd0, e.op == 2'b00});
          chk("or_cycles", n_or, {31'd0, e.op == 2'b01});
          chk("not_cycles", n_not, {31'd0, e.op == 2'b10});
`ifdef ALU_SEQ_FLAGS_EN
          chk("zero_flag", {31'd0, bus_if.zero_flag}, {31'd0, e.zf});
          chk("neg_flag", {31'd0, bus_if.neg_flag}, {31'd0, e.nf});
`endif
        end
        n_and = 0; n_or = 0; n_not = 0;
      end else begin
        chk("err_without_done", {31'd0, bus_if.err}, '0);
      end
      prev_done = bus_if.done;
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while (bus_if.busy && n < 20) begin
      @(negedge clock);
      n++;
    end
    if (bus_if.busy) chk("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic do_op(input logic [1:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] z,
                       input logic err, input logic zf, input logic nf,
                       input bit push);
    exp_t e;
    wait_idle();
    bus_if.start  = 1'b1;
    bus_if.op     = op;
    bus_if.bus_in = a;
    e = '{op: op, a: a, b: b, z: z, err: err, zf: zf, nf: nf, t: cyc};
    if (push) sb.push_back(e);
    @(negedge clock);
    bus_if.start  = 1'b0;
    bus_if.bus_in = b;
    bus_if.op     = ~op;
    @(negedge clock);
    bus_if.bus_in = $urandom;
  endtask

  initial begin : stim
    exp_t e;
    int n;
    bus_if.start  = 1'b0;
    bus_if.op     = 2'b00;
    bus_if.bus_in = '0;
    #12;
    chk("rst_busy", {31'd0, bus_if.busy}, '0);
    chk("rst_done", {31'd0, bus_if.done}, '0);
    chk("rst_z", bus_if.z_out, '0);
    chk("rst_a", bus_if.alu_a, '0);
    chk("rst_b", bus_if.alu_b, '0);
    @(negedge clock);
    clear = 1'b0;
    @(negedge clock);

    do_op(2'b00, 32'hF0F0_1234, 32'hFF00_FF00, 32'hF000_1200,
          1'b0, 1'b0, 1'b1, 1'b1);
    do_op(2'b01, 32'h0000_00FF, 32'h1200_0000, 32'h1200_00FF,
          1'b0, 1'b0, 1'b0, 1'b1);
    do_op(2'b10, 32'h0000_FFFF, 32'hDEAD_BEEF, 32'hFFFF_0000,
          1'b0, 1'b0, 1'b1, 1'b1);
    do_op(2'b11, 32'h1234_5678, 32'h0000_0000, 32'h0000_0000,
          1'b1, 1'b1, 1'b0, 1'b1);

    // start held for 10 cycles: accepts only at IDLE, 4 cycles apart
    wait_idle();
    bus_if.op     = 2'b00;
    bus_if.bus_in = 32'hAAAA_AAAA;
    for (int i = 0; i < 10; i++) begin
      bus_if.start = 1'b1;
      if (i % 4 == 0) begin
        e = '{op: 2'b00, a: 32'hAAAA_AAAA, b: 32'hAAAA_AAAA,
              z: 32'hAAAA_AAAA, err: 1'b0, zf: 1'b0, nf: 1'b1, t: cyc};
        sb.push_back(e);
      end
      @(negedge clock);
    end
    bus_if.start = 1'b0;

    // OR aborted by clear during EXEC: no done may follow
    do_op(2'b01, 32'h0000_0F00, 32'h0000_00F0, 32'h0000_0FF0,
          1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    clear = 1'b1;
    #1;
    chk("clr_busy", {31'd0, bus_if.busy}, '0);
    chk("clr_z", bus_if.z_out, '0);
    chk("clr_done", {31'd0, bus_if.done}, '0);
    chk("clr_a", bus_if.alu_a, '0);
    @(negedge clock);
    clear = 1'b0;
    @(negedge clock);

    do_op(2'b00, 32'h0000_00FF, 32'h0000_0F0F, 32'h0000_000F,
          1'b0, 1'b0, 1'b0, 1'b1);
    do_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000,
          1'b0, 1'b0, 1'b1, 1'b1);
    do_op(2'b00, 32'h0000_000F, 32'h0000_00F0, 32'h0000_0000,
          1'b0, 1'b1, 1'b0, 1'b1);

    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clock);
      n++;
    end
    chk("sb_drained", sb.size(), '0);
    repeat (4) @(negedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
